// File: rtl/ctrl_pkg.sv
// Shared definitions for the VeriRISC sequencing controller:
// phase encoding, opcode values and the ALU-opcode classifier.
package ctrl_pkg;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FTCH    = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Opcodes that read an operand from memory into the accumulator
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) ||
               (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ctrl_wdog.sv
// Memory wait-state watchdog: counts consecutive stalled wait cycles.
// Ports: i_clk, i_rst_n, i_wait_cyc (stalled cycle), i_clr, o_expire.
module ctrl_wdog #(
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_wait_cyc,
    input  logic i_clr,
    output logic o_expire
);

    localparam logic [TMR_W-1:0] LAST =
        (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    logic [TMR_W-1:0] r_cnt;

    // Expire on the stalled cycle that would take the count to TIMEOUT
    assign o_expire = (TIMEOUT > 0) && i_wait_cyc && (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_expire) begin
            r_cnt <= '0;
        end else if (i_wait_cyc) begin
            r_cnt <= r_cnt + TMR_W'(1);
        end
    end

endmodule

// File: rtl/seq_controller.sv
// VeriRISC sequencer: 8-phase counter, memory wait states, watchdog,
// sticky halt/bus error and single-step hold.
// Ports: i_clk, i_rst_n, i_opcode, i_zero, i_mem_rdy, i_resume,
// i_step_mode; o_sel..o_wr datapath controls, o_phase, o_bus_err, o_busy.
module seq_controller
    import ctrl_pkg::*;
#(
    parameter int OPC_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_zero,
    input  logic             i_mem_rdy,
    input  logic             i_resume,
    input  logic             i_step_mode,
    output logic             o_sel,
    output logic             o_rd,
    output logic             o_ld_ir,
    output logic             o_inc_pc,
    output logic             o_halt,
    output logic             o_ld_ac,
    output logic             o_data_e,
    output logic             o_ld_pc,
    output logic             o_wr,
    output logic [2:0]       o_phase,
    output logic             o_bus_err,
    output logic             o_busy
);

    phase_e r_phase, w_phase_nx;
    logic   r_halted, w_halted_nx;
    logic   r_hold, w_hold_nx;
    logic   r_bus_err, w_bus_err_nx;

    logic       w_nop;
    logic [2:0] w_op;
    logic       w_hlt, w_skz, w_sto, w_jmp, w_alu;
    logic       w_run, w_wait_ph, w_wait_cyc, w_adv, w_expire;

    // Wide opcodes beyond the 8 defined codes decode as NOP
    if (OPC_W > 3) begin : g_wide
        assign w_nop = |i_opcode[OPC_W-1:3];
    end else begin : g_narrow
        assign w_nop = 1'b0;
    end

    assign w_op  = i_opcode[2:0];
    assign w_hlt = ~w_nop & (w_op == OP_HLT);
    assign w_skz = ~w_nop & (w_op == OP_SKZ);
    assign w_sto = ~w_nop & (w_op == OP_STO);
    assign w_jmp = ~w_nop & (w_op == OP_JMP);
    assign w_alu = ~w_nop & is_aluop(w_op);

    assign w_run     = ~r_halted & ~r_hold;
    assign w_wait_ph = (r_phase == INST_FETCH) ||
                       (r_phase == OP_FTCH && w_alu) ||
                       (r_phase == STORE && w_sto);
    assign w_wait_cyc = w_run & w_wait_ph & ~i_mem_rdy;
    assign w_adv      = w_run & (~w_wait_ph | i_mem_rdy);

    // Any cycle that is not a stalled wait either has mem_rdy,
    // changes phase, or is halted/held: all of these clear the count.
    ctrl_wdog #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_wdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wait_cyc (w_wait_cyc),
        .i_clr      (~w_wait_cyc),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase   <= INST_ADDR;
            r_halted  <= 1'b0;
            r_hold    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_phase   <= w_phase_nx;
            r_halted  <= w_halted_nx;
            r_hold    <= w_hold_nx;
            r_bus_err <= w_bus_err_nx;
        end
    end

    always_comb begin
        w_phase_nx   = r_phase;
        w_halted_nx  = r_halted;
        w_hold_nx    = r_hold;
        w_bus_err_nx = r_bus_err;
        if (r_halted) begin
            if (i_resume) begin
                w_halted_nx  = 1'b0;
                w_bus_err_nx = 1'b0;
            end
        end else if (r_hold) begin
            if (i_resume) w_hold_nx = 1'b0;
        end else if (w_expire) begin
            w_bus_err_nx = 1'b1;
            w_halted_nx  = 1'b1;
            w_phase_nx   = INST_ADDR;
        end else if (w_adv) begin
            if (r_phase == OP_ADDR && w_hlt) begin
                w_halted_nx = 1'b1;
                w_phase_nx  = INST_ADDR;
            end else begin
                // STORE wraps to INST_ADDR through the 3-bit add
                w_phase_nx = phase_e'(r_phase + 3'd1);
                if (r_phase == STORE && i_step_mode) w_hold_nx = 1'b1;
            end
        end
    end

    always_comb begin
        o_sel    = 1'b0;
        o_rd     = 1'b0;
        o_ld_ir  = 1'b0;
        o_inc_pc = 1'b0;
        o_halt   = 1'b0;
        o_ld_ac  = 1'b0;
        o_data_e = 1'b0;
        o_ld_pc  = 1'b0;
        o_wr     = 1'b0;
        if (r_halted) begin
            o_halt = 1'b1;
        end else if (!r_hold) begin
            unique case (r_phase)
                INST_ADDR: o_sel = 1'b1;
                INST_FETCH: begin
                    o_sel = 1'b1;
                    o_rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    o_sel   = 1'b1;
                    o_rd    = 1'b1;
                    o_ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    o_inc_pc = 1'b1;
                    o_halt   = w_hlt;
                end
                OP_FTCH: o_rd = w_alu;
                ALU_OP: begin
                    o_rd     = w_alu;
                    o_inc_pc = w_skz & i_zero;
                    o_data_e = w_sto;
                    o_ld_pc  = w_jmp;
                end
                STORE: begin
                    o_rd     = w_alu;
                    o_ld_ac  = w_alu;
                    o_data_e = w_sto;
                    o_wr     = w_sto;
                    o_ld_pc  = w_jmp;
                end
            endcase
        end
    end

    assign o_phase   = r_phase;
    assign o_bus_err = r_bus_err;
    assign o_busy    = w_run;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: cycle model plus directed
// scenarios (no-wait, wait states, timeout, halt, step, reset).
module tb_seq_controller;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] opcode;
    logic       zero, mem_rdy, resume, step_mode;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_ac, data_e, ld_pc, wr;
    logic [2:0] phase;
    logic       bus_err, busy;

    always #5 clk = ~clk;

    seq_controller #(.OPC_W(3), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero),
        .i_mem_rdy(mem_rdy), .i_resume(resume), .i_step_mode(step_mode),
        .o_sel(sel), .o_rd(rd), .o_ld_ir(ld_ir), .o_inc_pc(inc_pc),
        .o_halt(halt), .o_ld_ac(ld_ac), .o_data_e(data_e),
        .o_ld_pc(ld_pc), .o_wr(wr), .o_phase(phase),
        .o_bus_err(bus_err), .o_busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ph = 0;
    bit m_halt = 0, m_hold = 0, m_err = 0;
    int m_wc = 0;

    function automatic bit is_alu(input int op);
        return op >= 2 && op <= 5;
    endfunction

    function automatic bit needs_mem(input int ph, input int op);
        return ph == 1 || (ph == 5 && is_alu(op)) || (ph == 7 && op == 6);
    endfunction

    // {sel,rd,ld_ir,inc_pc,halt,ld_ac,data_e,ld_pc,wr}
    function automatic logic [8:0] exp_ctrl(input int ph, input bit hs,
                                            input bit hd, input int op,
                                            input bit z);
        logic [8:0] c;
        c = '0;
        if (hs) return 9'b0_0001_0000;
        if (hd) return '0;
        c[8] = ph < 4;
        c[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && is_alu(op));
        c[6] = ph == 2 || ph == 3;
        c[5] = ph == 4 || (ph == 6 && op == 1 && z);
        c[4] = ph == 4 && op == 0;
        c[3] = ph == 7 && is_alu(op);
        c[2] = ph >= 6 && op == 6;
        c[1] = ph >= 6 && op == 7;
        c[0] = ph == 7 && op == 6;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_halt <= 0; m_hold <= 0; m_err <= 0; m_wc <= 0;
        end else if (m_halt) begin
            if (resume) begin m_halt <= 0; m_err <= 0; end
        end else if (m_hold) begin
            if (resume) m_hold <= 0;
        end else if (needs_mem(m_ph, int'(opcode)) && !mem_rdy) begin
            if (TO > 0 && m_wc + 1 == TO) begin
                m_err <= 1; m_halt <= 1; m_ph <= 0; m_wc <= 0;
            end else begin
                m_wc <= m_wc + 1;
            end
        end else begin
            m_wc <= 0;
            if (m_ph == 4 && opcode == 3'd0) begin
                m_halt <= 1; m_ph <= 0;
            end else begin
                m_ph <= (m_ph + 1) % 8;
                if (m_ph == 7 && step_mode) m_hold <= 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ctrl", {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_ac,
                       data_e, ld_pc, wr},
              {23'd0, exp_ctrl(m_ph, m_halt, m_hold, int'(opcode), zero)});
        check("phase", {29'd0, phase}, m_ph);
        check("bus_err", {31'd0, bus_err}, {31'd0, m_err});
        check("busy", {31'd0, busy}, {31'd0, !(m_halt || m_hold)});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_p0(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (phase != 3'd0 && n < 40);
        check("run_to_p0", {29'd0, phase}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, cyc, cnt;
        opcode = 3'd2; zero = 0; mem_rdy = 1; resume = 0; step_mode = 0;
        #2 rst_n = 0;
        #1;
        check("rst_phase", {29'd0, phase}, 0);
        check("rst_sel", {31'd0, sel}, 1);
        check("rst_rd", {31'd0, rd}, 0);
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_err", {31'd0, bus_err}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // ADD then JMP, no waits
        for (int i = 0; i < 8; i++) begin
            check("add_phase", {29'd0, phase}, i);
            check("add_ld_ac", {31'd0, ld_ac}, (i == 7) ? 1 : 0);
            tick();
        end
        opcode = 3'd7;
        for (int i = 0; i < 8; i++) begin
            check("jmp_phase", {29'd0, phase}, i);
            check("jmp_ld_pc", {31'd0, ld_pc}, (i >= 6) ? 1 : 0);
            tick();
        end

        // LDA with 3 stalled cycles in OP_FTCH
        opcode = 3'd5; k = 0; cyc = 0; cnt = 0;
        while (cyc < 40) begin
            if (phase == 3'd5 && k < 3) begin
                mem_rdy = 0; k++;
            end else begin
                mem_rdy = 1;
            end
            if (phase == 3'd5 && rd) cnt++;
            tick();
            cyc++;
            if (phase == 3'd0) break;
        end
        mem_rdy = 1;
        check("lda_cycles", cyc, 11);
        check("lda_p5_rd", cnt, 4);
        check("lda_err", {31'd0, bus_err}, 0);

        // mem_rdy on the last allowed cycle beats the watchdog
        opcode = 3'd2;
        tick();
        mem_rdy = 0;
        repeat (TO - 1) tick();
        check("edge_hold", {29'd0, phase}, 1);
        mem_rdy = 1;
        tick();
        check("edge_phase", {29'd0, phase}, 2);
        check("edge_err", {31'd0, bus_err}, 0);
        run_to_p0(n);

        // full timeout in INST_FETCH
        tick();
        mem_rdy = 0;
        n = 0;
        while (!bus_err && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", n, TO);
        check("to_halt", {31'd0, halt}, 1);
        check("to_phase", {29'd0, phase}, 0);
        repeat (3) tick();
        check("to_sticky", {31'd0, bus_err}, 1);
        resume = 1;
        tick();
        resume = 0;
        check("to_clr_err", {31'd0, bus_err}, 0);
        check("to_clr_halt", {31'd0, halt}, 0);
        check("to_restart_sel", {31'd0, sel}, 1);
        mem_rdy = 1;
        tick();
        check("to_fetch", {29'd0, phase}, 1);
        run_to_p0(n);

        // HLT
        opcode = 3'd0;
        repeat (4) tick();
        check("hlt_p4", {29'd0, phase}, 4);
        check("hlt_halt", {31'd0, halt}, 1);
        check("hlt_inc", {31'd0, inc_pc}, 1);
        tick();
        mem_rdy = 0;
        cnt = 0;
        repeat (20) begin
            if (halt && phase == 3'd0 &&
                {sel, rd, ld_ir, inc_pc, ld_ac, data_e, ld_pc, wr} == 8'd0)
                cnt++;
            tick();
        end
        check("hlt_hold", cnt, 20);
        check("hlt_no_err", {31'd0, bus_err}, 0);
        mem_rdy = 1; opcode = 3'd2; resume = 1;
        tick();
        resume = 0;
        check("hlt_res_halt", {31'd0, halt}, 0);
        check("hlt_res_sel", {31'd0, sel}, 1);
        run_to_p0(n);
        check("hlt_res_len", n, 8);

        // single step with two ADDs
        step_mode = 1;
        repeat (8) tick();
        check("step_busy", {31'd0, busy}, 0);
        step_mode = 0;
        cnt = 0;
        repeat (5) begin
            if (rd) cnt++;
            tick();
        end
        check("step_no_rd", cnt, 0);
        check("step_busy2", {31'd0, busy}, 0);
        resume = 1;
        tick();
        resume = 0;
        check("step_resumed", {31'd0, busy}, 1);
        run_to_p0(n);
        check("step_len", n, 8);
        check("step_busy3", {31'd0, busy}, 1);

        // SKZ with zero set then clear
        opcode = 3'd1; zero = 1;
        repeat (6) tick();
        check("skz_z1", {31'd0, inc_pc}, 1);
        repeat (2) tick();
        zero = 0;
        repeat (6) tick();
        check("skz_z0", {31'd0, inc_pc}, 0);
        repeat (2) tick();

        // reset during a STO write wait
        opcode = 3'd6;
        repeat (7) tick();
        check("sto_p7", {29'd0, phase}, 7);
        mem_rdy = 0;
        tick();
        check("sto_wait", {29'd0, phase}, 7);
        check("sto_wr", {31'd0, wr}, 1);
        #2 rst_n = 0;
        #1;
        check("rst_wr", {31'd0, wr}, 0);
        check("rst_phase2", {29'd0, phase}, 0);
        check("rst_sel2", {31'd0, sel}, 1);
        @(posedge clk);
        #1 rst_n = 1;
        mem_rdy = 1;
        tick();
        check("rst_restart", {29'd0, phase}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
